ex_mdu: RTL and testbench

- Next-generation execute stage for the RV32 core.
- Registered, handshaked execute unit, parametrised in XLEN:
  - single-cycle ALU for OP-IMM and OP instructions, plus MUL family;
  - iterative radix-2 divider for DIV/DIVU/REM/REMU.
- Sits between id and the regs write-back path.
- Stalls id through ready_o while a divide is in flight.

---
 rtl/ex_mdu_pkg.sv | 47 ++++
 rtl/ex_mdu_if.sv | 37 +++
 rtl/ex_div_iter.sv | 95 +++++++++
 rtl/ex_mdu.sv | 218 +++++++++++++++++++++
 tb/tb_ex_mdu.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/ex_mdu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ex_mdu_pkg
// Brief    : Shared encodings for the RV32/RV64 execute stage: opcodes,
//            funct3/funct7 values for OP/OP-IMM and the M extension, and
//            the execute-unit state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package ex_mdu_pkg;

  // Major opcodes handled by the execute unit
  localparam logic [6:0] INST_TYPE_I    = 7'b0010011;
  localparam logic [6:0] INST_TYPE_R_M  = 7'b0110011;

  // funct7 selectors for OP
  localparam logic [6:0] FUNCT7_BASE    = 7'b0000000;
  localparam logic [6:0] FUNCT7_ALT     = 7'b0100000;
  localparam logic [6:0] FUNCT7_M       = 7'b0000001;

  // funct3 values for OP / OP-IMM
  localparam logic [2:0] INST_ADD_SUB   = 3'b000;
  localparam logic [2:0] INST_SLL       = 3'b001;
  localparam logic [2:0] INST_SLT       = 3'b010;
  localparam logic [2:0] INST_SLTU      = 3'b011;
  localparam logic [2:0] INST_XOR       = 3'b100;
  localparam logic [2:0] INST_SR        = 3'b101;
  localparam logic [2:0] INST_OR        = 3'b110;
  localparam logic [2:0] INST_AND       = 3'b111;

  // funct3 values for the M extension
  localparam logic [2:0] INST_MUL       = 3'b000;
  localparam logic [2:0] INST_MULH      = 3'b001;
  localparam logic [2:0] INST_MULHSU    = 3'b010;
  localparam logic [2:0] INST_MULHU     = 3'b011;
  localparam logic [2:0] INST_DIV       = 3'b100;
  localparam logic [2:0] INST_DIVU      = 3'b101;
  localparam logic [2:0] INST_REM       = 3'b110;
  localparam logic [2:0] INST_REMU      = 3'b111;

  // Execute-unit control state
  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    DIV_BUSY = 1'b1
  } state_t;

endpackage
`default_nettype wire

// File: rtl/ex_mdu_if.sv
`default_nettype none
// ============================================================================
// Module   : ex_mdu_if
// Brief    : id -> ex -> write-back handshake bundle. The slave side is the
//            execute unit; the master side is the id stage plus write-back.
// Revision : 1.0 - initial release
// ============================================================================
interface ex_mdu_if #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
);
  logic              flush_i;
  logic              valid_i;
  logic              ready_o;
  logic [31:0]       inst_i;
  logic              reg_we_i;
  logic [REG_AW-1:0] reg_waddr_i;
  logic [XLEN-1:0]   op1_i;
  logic [XLEN-1:0]   op2_i;
  logic              valid_o;
  logic              ready_i;
  logic [XLEN-1:0]   reg_wdata_o;
  logic              reg_we_o;
  logic [REG_AW-1:0] reg_waddr_o;
  logic              busy_o;

  modport slave (
    input  flush_i, valid_i, inst_i, reg_we_i, reg_waddr_i, op1_i, op2_i, ready_i,
    output ready_o, valid_o, reg_wdata_o, reg_we_o, reg_waddr_o, busy_o
  );

  modport master (
    output flush_i, valid_i, inst_i, reg_we_i, reg_waddr_i, op1_i, op2_i, ready_i,
    input  ready_o, valid_o, reg_wdata_o, reg_we_o, reg_waddr_o, busy_o
  );
endinterface
`default_nettype wire

// File: rtl/ex_div_iter.sv
`default_nettype none
// ============================================================================
// Module   : ex_div_iter
// Brief    : Iterative radix-2 restoring divider. Takes XLEN steps per
//            divide; the final step's signed quotient/remainder are
//            presented combinationally together with done.
// Revision : 1.0 - initial release
// ============================================================================
module ex_div_iter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,        // asynchronous, active-low
  input  logic            kill,
  input  logic            start,
  input  logic            is_signed,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder,
  output logic            done
);

  localparam int c_cw = $clog2(XLEN);

  logic [c_cw-1:0] r_count;
  logic            r_busy;
  logic [XLEN-1:0] r_quot;
  logic [XLEN-1:0] r_rem;
  logic [XLEN-1:0] r_dvs;
  logic            r_neg_q;
  logic            r_neg_r;

  logic            w_dvd_neg;
  logic            w_dvs_neg;
  logic [XLEN-1:0] w_dvd_abs;
  logic [XLEN-1:0] w_dvs_abs;
  logic [XLEN:0]   w_shift;
  logic [XLEN:0]   w_diff;
  logic            w_fits;
  logic [XLEN-1:0] w_rem_next;
  logic [XLEN-1:0] w_quot_next;

  // Operand magnitudes; the most negative value maps onto 2^(XLEN-1) unsigned
  assign w_dvd_neg = is_signed & dividend[XLEN-1];
  assign w_dvs_neg = is_signed & divisor[XLEN-1];
  assign w_dvd_abs = w_dvd_neg ? -dividend : dividend;
  assign w_dvs_abs = w_dvs_neg ? -divisor  : divisor;

  // One restoring step: shift the next dividend bit in, subtract if it fits
  assign w_shift     = {r_rem, r_quot[XLEN-1]};
  assign w_diff      = w_shift - {1'b0, r_dvs};
  assign w_fits      = ~w_diff[XLEN];
  assign w_rem_next  = w_fits ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];
  assign w_quot_next = {r_quot[XLEN-2:0], w_fits};

  // Last step result with sign fixup applied
  assign done      = r_busy && (r_count == '0);
  assign quotient  = r_neg_q ? -w_quot_next : w_quot_next;
  assign remainder = r_neg_r ? -w_rem_next  : w_rem_next;

  // Step counter and shift-subtract registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
      r_busy  <= 1'b0;
      r_quot  <= '0;
      r_rem   <= '0;
      r_dvs   <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else if (kill) begin
      r_count <= '0;
      r_busy  <= 1'b0;
    end else if (start) begin
      r_count <= c_cw'(XLEN - 1);
      r_busy  <= 1'b1;
      r_quot  <= w_dvd_abs;
      r_rem   <= '0;
      r_dvs   <= w_dvs_abs;
      r_neg_q <= w_dvd_neg ^ w_dvs_neg;
      r_neg_r <= w_dvd_neg;
    end else if (r_busy) begin
      r_quot <= w_quot_next;
      r_rem  <= w_rem_next;
      if (r_count == '0) begin
        r_busy <= 1'b0;
      end else begin
        r_count <= r_count - c_cw'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/ex_mdu.sv
`default_nettype none
// ============================================================================
// Module   : ex_mdu
// Brief    : Registered, handshaked execute stage: single-cycle ALU and
//            multiplier, special-case divides resolved at accept, and an
//            iterative divider that stalls id while it runs.
// Revision : 1.0 - initial release
// ============================================================================
module ex_mdu
  import ex_mdu_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5,
  parameter int DIV_EN = 1
) (
  input  logic    clk,
  input  logic    rst,                // asynchronous, active-low
  ex_mdu_if.slave bus
);

  localparam int              c_shw       = $clog2(XLEN);
  localparam logic [XLEN-1:0] c_zero_word = '0;
  localparam logic [XLEN-1:0] c_int_min   = {1'b1, {(XLEN-1){1'b0}}};

  state_t            r_state;
  state_t            w_state_next;
  logic              r_valid;
  logic              r_we;
  logic [XLEN-1:0]   r_wdata;
  logic [REG_AW-1:0] r_waddr;
  logic              r_div_sel_rem;
  logic              r_div_we;
  logic [REG_AW-1:0] r_div_waddr;

  logic [6:0]        w_opcode;
  logic [2:0]        w_funct3;
  logic [6:0]        w_funct7;
  logic [c_shw-1:0]  w_shamt;
  logic              w_ready;
  logic              w_accept;
  logic              w_is_div;
  logic              w_div_signed;
  logic              w_div_sel_rem;
  logic              w_div_by_zero;
  logic              w_div_ovf;
  logic              w_div_start;
  logic              w_load_single;
  logic              w_div_done;
  logic [XLEN-1:0]   w_div_quot;
  logic [XLEN-1:0]   w_div_rem;
  logic              w_mul_a_sgn;
  logic              w_mul_b_sgn;
  logic [2*XLEN+1:0] w_mul_a;
  logic [2*XLEN+1:0] w_mul_b;
  logic [2*XLEN+1:0] w_prod;
  logic [XLEN-1:0]   w_result;
  logic              w_unused_bits;

  assign w_opcode = bus.inst_i[6:0];
  assign w_funct3 = bus.inst_i[14:12];
  assign w_funct7 = bus.inst_i[31:25];
  assign w_shamt  = bus.op2_i[c_shw-1:0];

  // Fields that only matter to other stages (rs/rd indices) and product guard bits
  assign w_unused_bits = ^{bus.inst_i[24:15], bus.inst_i[11:7], w_prod[2*XLEN+1:2*XLEN]};

  // Handshake: accept only from IDLE with room in the output register
  assign w_ready     = (r_state == IDLE) && (!r_valid || bus.ready_i);
  assign w_accept    = bus.valid_i && w_ready && !bus.flush_i;
  assign bus.ready_o = w_ready;

  // Divide classification and special cases resolved without iterating
  assign w_is_div      = (w_opcode == INST_TYPE_R_M) && (w_funct7 == FUNCT7_M) && w_funct3[2];
  assign w_div_signed  = !w_funct3[0];
  assign w_div_sel_rem = w_funct3[1];
  assign w_div_by_zero = (bus.op2_i == c_zero_word);
  assign w_div_ovf     = w_div_signed && (bus.op1_i == c_int_min) && (bus.op2_i == '1);
  assign w_div_start   = w_accept && w_is_div && !w_div_by_zero && !w_div_ovf && (DIV_EN != 0);
  assign w_load_single = w_accept && !w_div_start;

  // Full 2*XLEN product from operands sign- or zero-extended per MUL variant
  assign w_mul_a_sgn = (w_funct3 == INST_MULH) || (w_funct3 == INST_MULHSU);
  assign w_mul_b_sgn = (w_funct3 == INST_MULH);
  assign w_mul_a     = {{(XLEN+2){w_mul_a_sgn & bus.op1_i[XLEN-1]}}, bus.op1_i};
  assign w_mul_b     = {{(XLEN+2){w_mul_b_sgn & bus.op2_i[XLEN-1]}}, bus.op2_i};
  assign w_prod      = w_mul_a * w_mul_b;

  generate
    if (DIV_EN != 0) begin : g_div
      ex_div_iter #(.XLEN(XLEN)) u_div (
        .clk       (clk),
        .rst       (rst),
        .kill      (bus.flush_i),
        .start     (w_div_start),
        .is_signed (w_div_signed),
        .dividend  (bus.op1_i),
        .divisor   (bus.op2_i),
        .quotient  (w_div_quot),
        .remainder (w_div_rem),
        .done      (w_div_done)
      );
    end else begin : g_no_div
      assign w_div_quot = c_zero_word;
      assign w_div_rem  = c_zero_word;
      assign w_div_done = 1'b0;
    end
  endgenerate

  // Single-cycle result: ALU, multiplier and the non-iterating divide cases
  always_comb begin
    w_result = c_zero_word;
    if (w_opcode == INST_TYPE_I) begin
      case (w_funct3)
        INST_ADD_SUB: w_result = bus.op1_i + bus.op2_i;
        INST_SLT:     w_result = {{(XLEN-1){1'b0}}, ($signed(bus.op1_i) < $signed(bus.op2_i))};
        INST_SLTU:    w_result = {{(XLEN-1){1'b0}}, (bus.op1_i < bus.op2_i)};
        INST_XOR:     w_result = bus.op1_i ^ bus.op2_i;
        INST_OR:      w_result = bus.op1_i | bus.op2_i;
        INST_AND:     w_result = bus.op1_i & bus.op2_i;
        INST_SLL:     w_result = bus.op1_i << w_shamt;
        default:      w_result = w_funct7[5] ? $unsigned($signed(bus.op1_i) >>> w_shamt)
                                             : (bus.op1_i >> w_shamt);
      endcase
    end else if (w_opcode == INST_TYPE_R_M) begin
      if (w_funct7 == FUNCT7_M) begin
        if (!w_funct3[2]) begin
          w_result = (w_funct3 == INST_MUL) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];
        end else if (DIV_EN == 0) begin
          w_result = c_zero_word;
        end else if (w_div_by_zero) begin
          w_result = w_div_sel_rem ? bus.op1_i : {XLEN{1'b1}};
        end else begin
          w_result = w_div_sel_rem ? c_zero_word : bus.op1_i;
        end
      end else if ((w_funct7 == FUNCT7_BASE) || (w_funct7 == FUNCT7_ALT)) begin
        case (w_funct3)
          INST_ADD_SUB: w_result = w_funct7[5] ? (bus.op1_i - bus.op2_i) : (bus.op1_i + bus.op2_i);
          INST_SLL:     w_result = bus.op1_i << w_shamt;
          INST_SLT:     w_result = {{(XLEN-1){1'b0}}, ($signed(bus.op1_i) < $signed(bus.op2_i))};
          INST_SLTU:    w_result = {{(XLEN-1){1'b0}}, (bus.op1_i < bus.op2_i)};
          INST_XOR:     w_result = bus.op1_i ^ bus.op2_i;
          INST_SR:      w_result = w_funct7[5] ? $unsigned($signed(bus.op1_i) >>> w_shamt)
                                               : (bus.op1_i >> w_shamt);
          INST_OR:      w_result = bus.op1_i | bus.op2_i;
          default:      w_result = bus.op1_i & bus.op2_i;
        endcase
      end
    end
  end

  // Control state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state: enter DIV_BUSY on an iterating divide, leave on done or flush
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:     if (w_div_start) w_state_next = DIV_BUSY;
      DIV_BUSY: if (w_div_done)  w_state_next = IDLE;
      default:  w_state_next = IDLE;
    endcase
    if (bus.flush_i) begin
      w_state_next = IDLE;
    end
  end

  // Destination info of the divide in flight, captured at accept
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_div_sel_rem <= 1'b0;
      r_div_we      <= 1'b0;
      r_div_waddr   <= '0;
    end else if (w_div_start) begin
      r_div_sel_rem <= w_div_sel_rem;
      r_div_we      <= bus.reg_we_i;
      r_div_waddr   <= bus.reg_waddr_i;
    end
  end

  // Output register: load single-cycle or divide result, hold under backpressure
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= 1'b0;
      r_we    <= 1'b0;
      r_wdata <= '0;
      r_waddr <= '0;
    end else if (bus.flush_i) begin
      r_valid <= 1'b0;
      r_we    <= 1'b0;
    end else if (w_load_single) begin
      r_valid <= 1'b1;
      r_wdata <= w_result;
      r_waddr <= bus.reg_waddr_i;
      r_we    <= bus.reg_we_i && (bus.reg_waddr_i != '0);
    end else if (w_div_done) begin
      r_valid <= 1'b1;
      r_wdata <= r_div_sel_rem ? w_div_rem : w_div_quot;
      r_waddr <= r_div_waddr;
      r_we    <= r_div_we && (r_div_waddr != '0);
    end else if (bus.ready_i) begin
      r_valid <= 1'b0;
    end
  end

  assign bus.valid_o     = r_valid;
  assign bus.reg_wdata_o = r_wdata;
  assign bus.reg_we_o    = r_we;
  assign bus.reg_waddr_o = r_waddr;
  assign bus.busy_o      = (r_state == DIV_BUSY);

endmodule
`default_nettype wire

// File: tb/tb_ex_mdu.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex_mdu
// Brief    : Directed self-checking bench for ex_mdu (XLEN=32).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ex_mdu;

  logic clk = 1'b0;
  logic rst;
  int   n_total = 0;
  int   n_bad   = 0;

  always #5 clk = ~clk;

  ex_mdu_if #(.XLEN(32), .REG_AW(5)) bus ();

  ex_mdu #(.XLEN(32), .REG_AW(5), .DIV_EN(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Instruction word with zero rs/rd fields
  function automatic logic [31:0] enc(input logic [6:0] f7, input logic [2:0] f3,
                                      input logic [6:0] op);
    return {f7, 5'd0, 5'd0, f3, 5'd0, op};
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] inst, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd);
    bus.inst_i      = inst;
    bus.op1_i       = a;
    bus.op2_i       = b;
    bus.reg_waddr_i = rd;
    bus.reg_we_i    = 1'b1;
    bus.valid_i     = 1'b1;
  endtask

  // Issue one single-cycle op and check the result one cycle later
  task automatic single(input string tag, input logic [31:0] inst, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp);
    drive(inst, a, b, rd);
    step();
    bus.valid_i = 1'b0;
    chk({tag, "_valid"}, 64'(bus.valid_o), 64'd1);
    chk(tag, 64'(bus.reg_wdata_o), 64'(exp));
  endtask

  // Issue an iterating divide, check busy duration, latency and result
  task automatic div_run(input string tag, input logic [31:0] inst, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp);
    int lat;
    int busy_n;
    drive(inst, a, b, 5'd9);
    step();
    bus.valid_i = 1'b0;
    lat    = 1;
    busy_n = 0;
    while (!bus.valid_o && lat < 40) begin
      if (bus.busy_o) busy_n++;
      step();
      lat++;
    end
    chk({tag, "_lat"},  64'(lat),    64'd33);
    chk({tag, "_busy"}, 64'(busy_n), 64'd32);
    chk(tag, 64'(bus.reg_wdata_o), 64'(exp));
  endtask

  localparam logic [6:0] OPI = 7'b0010011;
  localparam logic [6:0] OPR = 7'b0110011;

  initial begin
    int seen;
    rst             = 1'b0;
    bus.flush_i     = 1'b0;
    bus.valid_i     = 1'b0;
    bus.inst_i      = '0;
    bus.reg_we_i    = 1'b0;
    bus.reg_waddr_i = '0;
    bus.op1_i       = '0;
    bus.op2_i       = '0;
    bus.ready_i     = 1'b1;

    #12;
    chk("rst_valid", 64'(bus.valid_o),     64'd0);
    chk("rst_wdata", 64'(bus.reg_wdata_o), 64'd0);
    chk("rst_we",    64'(bus.reg_we_o),    64'd0);
    chk("rst_waddr", 64'(bus.reg_waddr_o), 64'd0);
    chk("rst_busy",  64'(bus.busy_o),      64'd0);
    rst = 1'b1;
    step();

    // ADDI then back-to-back SUB
    single("addi", enc(7'h00, 3'b000, OPI), 32'd5, 32'hFFFF_FFFD, 5'd7, 32'd2);
    chk("addi_waddr", 64'(bus.reg_waddr_o), 64'd7);
    chk("addi_we",    64'(bus.reg_we_o),    64'd1);
    single("sub",    enc(7'h20, 3'b000, OPR), 32'd10, 32'd4, 5'd8, 32'd6);
    single("slti",   enc(7'h00, 3'b010, OPI), 32'hFFFF_FFFF, 32'd1, 5'd1, 32'd1);
    single("srai",   enc(7'h20, 3'b101, OPI), 32'h8000_0000, 32'd4, 5'd1, 32'hF800_0000);
    single("srli",   enc(7'h00, 3'b101, OPI), 32'h8000_0000, 32'd4, 5'd1, 32'h0800_0000);
    single("sltu",   enc(7'h00, 3'b011, OPR), 32'd1, 32'hFFFF_FFFF, 5'd1, 32'd1);
    single("xor",    enc(7'h00, 3'b100, OPR), 32'h0000_F0F0, 32'h0000_FF00, 5'd1, 32'h0000_0FF0);
    single("mul",    enc(7'h01, 3'b000, OPR), 32'd7, 32'd6, 5'd1, 32'd42);
    single("mulh",   enc(7'h01, 3'b001, OPR), 32'hFFFF_FFFE, 32'd3, 5'd1, 32'hFFFF_FFFF);

    // Iterating divides
    div_run("div", enc(7'h01, 3'b100, OPR), 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFA);
    div_run("rem", enc(7'h01, 3'b110, OPR), 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFE);

    // Special-case divides at single-cycle latency
    single("divu_by0", enc(7'h01, 3'b101, OPR), 32'd7, 32'd0, 5'd2, 32'hFFFF_FFFF);
    single("rem_ovf",  enc(7'h01, 3'b110, OPR), 32'h8000_0000, 32'hFFFF_FFFF, 5'd2, 32'd0);
    single("div_ovf",  enc(7'h01, 3'b100, OPR), 32'h8000_0000, 32'hFFFF_FFFF, 5'd2, 32'h8000_0000);
    step();
    chk("drain_valid", 64'(bus.valid_o), 64'd0);

    // Backpressure
    bus.ready_i = 1'b0;
    drive(enc(7'h00, 3'b000, OPR), 32'd1, 32'd2, 5'd3);
    step();
    drive(enc(7'h00, 3'b000, OPR), 32'd100, 32'd100, 5'd4);
    for (int i = 0; i < 5; i++) begin
      chk("bp_ready", 64'(bus.ready_o),     64'd0);
      chk("bp_valid", 64'(bus.valid_o),     64'd1);
      chk("bp_wdata", 64'(bus.reg_wdata_o), 64'd3);
      chk("bp_waddr", 64'(bus.reg_waddr_o), 64'd3);
      step();
    end
    bus.valid_i = 1'b0;
    bus.ready_i = 1'b1;
    #1;
    chk("bp_release_ready", 64'(bus.ready_o), 64'd1);
    step();
    chk("bp_after_valid", 64'(bus.valid_o), 64'd0);
    chk("bp_after_ready", 64'(bus.ready_o), 64'd1);

    // Flush during iteration 10 of a divide
    drive(enc(7'h01, 3'b100, OPR), 32'd100, 32'd7, 5'd5);
    step();
    bus.valid_i = 1'b0;
    chk("fl_busy_on", 64'(bus.busy_o), 64'd1);
    repeat (9) step();
    bus.flush_i = 1'b1;
    step();
    bus.flush_i = 1'b0;
    chk("fl_busy", 64'(bus.busy_o),  64'd0);
    chk("fl_valid", 64'(bus.valid_o), 64'd0);
    seen = 0;
    for (int i = 0; i < 35; i++) begin
      step();
      if (bus.valid_o) seen = 1;
    end
    chk("fl_no_result", 64'(seen), 64'd0);
    single("fl_addi", enc(7'h00, 3'b000, OPI), 32'd1, 32'd1, 5'd6, 32'd2);

    // Instruction presented together with flush is dropped
    drive(enc(7'h00, 3'b000, OPI), 32'd5, 32'd5, 5'd6);
    bus.flush_i = 1'b1;
    step();
    bus.flush_i = 1'b0;
    bus.valid_i = 1'b0;
    chk("fl_drop_valid", 64'(bus.valid_o),  64'd0);
    chk("fl_drop_we",    64'(bus.reg_we_o), 64'd0);

    // rd = 0 suppresses the write enable
    single("mulhu_x0", enc(7'h01, 3'b011, OPR), 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, 32'hFFFF_FFFE);
    chk("mulhu_x0_we", 64'(bus.reg_we_o), 64'd0);

    // Asynchronous reset in the middle of a divide
    drive(enc(7'h01, 3'b101, OPR), 32'd1000, 32'd3, 5'd9);
    step();
    bus.valid_i = 1'b0;
    repeat (5) step();
    #3 rst = 1'b0;
    #1;
    chk("arst_valid", 64'(bus.valid_o),     64'd0);
    chk("arst_busy",  64'(bus.busy_o),      64'd0);
    chk("arst_wdata", 64'(bus.reg_wdata_o), 64'd0);
    chk("arst_we",    64'(bus.reg_we_o),    64'd0);
    chk("arst_waddr", 64'(bus.reg_waddr_o), 64'd0);
    chk("arst_ready", 64'(bus.ready_o),     64'd1);
    #2 rst = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (bus.valid_o) seen = 1;
    end
    chk("arst_no_result", 64'(seen), 64'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
